// File: rtl/wbc_arbiter.sv
// Wishbone classic N-master to 1-slave arbiter: round-robin grant held for the
// whole CYC, one idle cycle between grants, optional STB-without-ACK timeout.
module wbc_arbiter #(
  parameter int unsigned NM      = 4,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned SW      = DW/8,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NM-1:0]    i_mcyc,
  input  logic [NM-1:0]    i_mstb,
  input  logic [NM-1:0]    i_mwe,
  input  logic [NM*AW-1:0] i_maddr,
  input  logic [NM*DW-1:0] i_mdata,
  input  logic [NM*SW-1:0] i_msel,
  output logic [NM-1:0]    o_mack,
  output logic [NM*DW-1:0] o_mdata,
  output logic [NM-1:0]    o_merr,
  output logic             o_scyc,
  output logic             o_sstb,
  output logic             o_swe,
  output logic [AW-1:0]    o_saddr,
  output logic [DW-1:0]    o_sdata,
  output logic [SW-1:0]    o_ssel,
  input  logic             i_sack,
  input  logic [DW-1:0]    i_sdata,
  input  logic             i_serr,
  output logic [NM-1:0]    o_grant,
  output logic             o_busy
);

  localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic {S_IDLE, S_GRANTED} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] gidx, gidx_nx;
  logic [IW-1:0] last, last_nx;
  logic [NM-1:0] grant_nx;
  logic [TW-1:0] cnt, cnt_nx;
  logic [IW-1:0] win;
  logic          win_ok;
  logic          granted;
  logic          stb_raw;
  logic          to_err;

  // Round-robin search starting just after the previous owner, wrapping
  always_comb begin
    int unsigned k;
    win    = '0;
    win_ok = 1'b0;
    k      = 0;
    for (int unsigned i = 1; i <= NM; i++) begin
      k = 32'(last) + i;
      if (k >= NM) k = k - NM;
      if (!win_ok && i_mcyc[IW'(k)]) begin
        win_ok = 1'b1;
        win    = IW'(k);
      end
    end
  end

  always_comb begin
    state_nx = state;
    gidx_nx  = gidx;
    last_nx  = last;
    grant_nx = o_grant;
    case (state)
      S_IDLE: begin
        if (win_ok) begin
          state_nx = S_GRANTED;
          gidx_nx  = win;
          grant_nx = NM'(1) << win;
        end
      end
      S_GRANTED: begin
        if (!i_mcyc[gidx]) begin
          state_nx = S_IDLE;
          last_nx  = gidx;
          grant_nx = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        grant_nx = '0;
      end
    endcase
  end

  assign granted = (state == S_GRANTED);
  assign stb_raw = granted & i_mstb[gidx];

  // Raw STB feeds the counter so that forcing o_sstb low cannot loop back
  always_comb begin
    to_err = 1'b0;
    cnt_nx = '0;
    if (TIMEOUT != 0) begin
      to_err = stb_raw && !i_sack && !i_serr && (cnt == TW'(TIMEOUT));
      if (!stb_raw || i_sack || i_serr || to_err)
        cnt_nx = '0;
      else
        cnt_nx = cnt + TW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state   <= S_IDLE;
      gidx    <= '0;
      last    <= IW'(NM-1);
      o_grant <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      gidx    <= gidx_nx;
      last    <= last_nx;
      o_grant <= grant_nx;
      cnt     <= cnt_nx;
    end
  end

  always_comb begin
    o_scyc  = 1'b0;
    o_sstb  = 1'b0;
    o_swe   = 1'b0;
    o_saddr = '0;
    o_sdata = '0;
    o_ssel  = '0;
    o_mack  = '0;
    o_merr  = '0;
    if (granted) begin
      o_scyc       = i_mcyc[gidx];
      o_sstb       = stb_raw & ~to_err;
      o_swe        = i_mwe[gidx];
      o_saddr      = i_maddr[32'(gidx)*AW +: AW];
      o_sdata      = i_mdata[32'(gidx)*DW +: DW];
      o_ssel       = i_msel[32'(gidx)*SW +: SW];
      o_mack[gidx] = i_sack;
      o_merr[gidx] = i_serr | to_err;
    end
  end

  assign o_mdata = {NM{i_sdata}};
  assign o_busy  = granted;

endmodule

// File: tb/tb_wbc_arbiter.sv
// Self-checking bench for wbc_arbiter (NM=4, TIMEOUT=5): grant order, idle gap,
// timeout error, ACK/timeout coincidence and mid-transfer reset.
module tb_wbc_arbiter;
  localparam int unsigned NM = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NM-1:0]    mcyc, mstb, mwe;
  logic [NM*AW-1:0] maddr;
  logic [NM*DW-1:0] mdata_w;
  logic [NM*SW-1:0] msel;
  logic [NM-1:0]    mack, merr;
  logic [NM*DW-1:0] mdata_r;
  logic             scyc, sstb, swe;
  logic [AW-1:0]    saddr;
  logic [DW-1:0]    sdata_w;
  logic [SW-1:0]    ssel;
  logic             sack, serr;
  logic [DW-1:0]    sdata_r;
  logic [NM-1:0]    grant;
  logic             busy;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  wbc_arbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(5), .TW(8)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_mcyc(mcyc), .i_mstb(mstb), .i_mwe(mwe),
    .i_maddr(maddr), .i_mdata(mdata_w), .i_msel(msel),
    .o_mack(mack), .o_mdata(mdata_r), .o_merr(merr),
    .o_scyc(scyc), .o_sstb(sstb), .o_swe(swe),
    .o_saddr(saddr), .o_sdata(sdata_w), .o_ssel(ssel),
    .i_sack(sack), .i_sdata(sdata_r), .i_serr(serr),
    .o_grant(grant), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [NM-1:0] g);
    g = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) begin
        g = grant;
        return;
      end
    end
    chk("grant_wait", {127'b0, busy}, 128'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NM-1:0] g;
    int            m;
    logic          tmo;

    rst_n = 1'b0; mcyc = '0; mstb = '0; mwe = 4'b1010;
    sack = 1'b0; serr = 1'b0; sdata_r = 32'h1234_5678;
    for (int k = 0; k < int'(NM); k++) begin
      maddr[k*AW +: AW]   = 32'hA000_0000 + 32'(k);
      mdata_w[k*DW +: DW] = 32'hD000_0000 + 32'(k);
      msel[k*SW +: SW]    = 4'(k + 1);
    end

    repeat (2) step();
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_scyc", scyc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mack", mack, 0);
    step();
    rst_n = 1'b1;

    // Master 0 loses priority only because it is not requesting
    mcyc = 4'b0110; mstb = 4'b0110;
    step();
    @(negedge clk);
    chk("t1_grant", grant, 4'b0010);
    chk("t1_saddr", saddr, 32'hA000_0001);
    chk("t1_sdata", sdata_w, 32'hD000_0001);
    chk("t1_ssel", ssel, 4'h2);
    chk("t1_swe", swe, 1);
    chk("t1_sstb", sstb, 1);
    chk("t1_mack_pre", mack, 0);
    sack = 1'b1;
    #1;
    chk("t1_mack", mack, 4'b0010);
    chk("t1_merr", merr, 0);
    chk("t1_mdata", mdata_r, {4{32'h1234_5678}});
    step();
    sack = 1'b0; mcyc = 4'b0100; mstb = 4'b0100;
    step();
    @(negedge clk);
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_grant", grant, 0);
    step();
    @(negedge clk);
    chk("t2_grant", grant, 4'b0100);
    chk("t2_saddr", saddr, 32'hA000_0002);
    step();
    mcyc = '0; mstb = '0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // Round robin with all masters requesting
    mcyc = 4'b1111; mstb = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int n = 0; n < 5; n++) begin
      wait_grant(g);
      m = exp_q.pop_front();
      chk("rr_grant", g, 128'(4'b0001 << m));
      sack = 1'b1;
      step();
      sack = 1'b0;
      mcyc = 4'b1111 & ~g;
      step();
      mcyc = 4'b1111;
    end
    mcyc = '0; mstb = '0;
    repeat (2) step();

    // Timeout: error in 6th STB cycle, restart, then ACK wins on coincidence
    mcyc = 4'b0001; mstb = 4'b0001;
    step();
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 18) begin
        sack = 1'b1;
        #1;
        chk("to_ack_mack", mack, 4'b0001);
        chk("to_ack_merr", merr, 0);
        chk("to_ack_sstb", sstb, 1);
      end else begin
        tmo = (c == 6) || (c == 12);
        chk("to_merr", merr, tmo ? 4'b0001 : 4'b0000);
        chk("to_sstb", sstb, !tmo);
      end
    end
    step();
    sack = 1'b0; mcyc = '0; mstb = '0;
    repeat (2) step();

    // Mid-transfer reset with master 3 granted
    mcyc = 4'b1000; mstb = 4'b1000;
    step();
    @(negedge clk);
    chk("r_grant3", grant, 4'b1000);
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("r_grant0", grant, 0);
    chk("r_scyc", scyc, 0);
    chk("r_busy", busy, 0);
    sack = 1'b1;
    #1;
    chk("r_late_ack", mack, 0);
    step();
    rst_n = 1'b1; sack = 1'b0; mcyc = 4'b1001; mstb = 4'b1001;
    step();
    @(negedge clk);
    chk("r_after_grant", grant, 4'b0001);
    chk("r_after_saddr", saddr, 32'hA000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wbc_arbiter.md
Name: wbc_arbiter

Overview:
- Wishbone classic N-master to 1-slave arbiter; the mirror of the 1-to-N address router, placed in front of a shared slave port (e.g. SPI flash or SRAM) that CPU, DMA and display engines all access.
- Round-robin grant, locked for the whole bus cycle (CYC high), one cycle of arbitration latency.
- Optional bus-timeout error generator so a hung slave cannot stall a master forever.

Parameters:
- NM, 4, number of masters (2..16)
- AW, 32, address width
- DW, 32, data width
- SW, DW/8, byte-select width
- TIMEOUT, 255, cycles of STB without ACK/ERR before an error is forced; 0 disables the timeout
- TW, 8, timeout counter width; TIMEOUT must be < 2^TW

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-low reset (0 = reset)
- i_mcyc  in  NM  per-master CYC
- i_mstb  in  NM  per-master STB
- i_mwe  in  NM  per-master WE
- i_maddr  in  NM*AW  packed master addresses; master k occupies [k*AW +: AW]
- i_mdata  in  NM*DW  packed master write data
- i_msel  in  NM*SW  packed master byte selects
- o_mack  out  NM  per-master ACK
- o_mdata  out  NM*DW  read data; every lane carries i_sdata
- o_merr  out  NM  per-master ERR
- o_scyc  out  1  slave CYC
- o_sstb  out  1  slave STB
- o_swe  out  1  slave WE
- o_saddr  out  AW  slave address
- o_sdata  out  DW  slave write data
- o_ssel  out  SW  slave byte select
- i_sack  in  1  slave ACK
- i_sdata  in  DW  slave read data
- i_serr  in  1  slave ERR
- o_grant  out  NM  one-hot registered grant; all zero when idle
- o_busy  out  1  high in GRANTED state

Behaviour:

State machine (2 states):
- IDLE
  - No grant.
  - o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel, o_mack and o_merr are all 0.
  - If any i_mcyc bit is high at a rising edge, pick a winner, register it in o_grant and go to GRANTED.
- GRANTED (grant index g)
  - Slave outputs are driven combinationally from master g.
  - o_mack[g] = i_sack; o_merr[g] = i_serr | to_err.
  - All other o_mack and o_merr bits are 0.
- GRANTED -> IDLE on the edge where i_mcyc[g] is low. Record last = g.
- One mandatory IDLE cycle separates consecutive grants. There is no back-to-back re-grant.

Arbitration:
- Round-robin search from (last+1) mod NM upward, wrapping.
- The first master with i_mcyc set wins.
- STB is not required to win; CYC alone requests the bus.
- Grant is never revoked while i_mcyc[g] stays high, regardless of other requests.

Latency:
- Master raises CYC+STB at cycle 0; o_grant and o_scyc/o_sstb are high at cycle 1.
- ACK passes back combinationally in the same cycle as i_sack.

Timeout (TIMEOUT > 0):
- Counter is cleared when o_sstb is low, or i_sack or i_serr is high, or in IDLE.
- Otherwise the counter increments each cycle.
- When the count equals TIMEOUT and no ACK/ERR is present:
  - to_err is high for exactly that cycle and o_sstb is forced low.
  - The counter then clears.
- If i_sack and the timeout coincide, ACK wins and to_err stays low.
- TIMEOUT = 0: to_err is constantly 0 and the counter is held at 0.

Other rules:
- i_sack and i_serr are ignored in IDLE.
- o_mdata: all NM lanes equal i_sdata in every state. Only the ACK gating distinguishes the masters.

Reset (i_reset low at an edge):
- State IDLE, o_grant = 0, last = NM-1 (so master 0 wins first), counter = 0.
- All outputs are 0 from the following cycle.
- A reset mid-transfer drops the grant at that edge.
- Any slave ACK arriving after reset is discarded.

Test Plan:
- After reset, assert i_mcyc = 4'b0110 with STB on both -> o_grant = 4'b0010 at cycle 1; o_saddr = master 1 address; i_sack pulse -> o_mack = 4'b0010 only.
- Master 1 drops CYC while master 2 is held -> one IDLE cycle (o_busy = 0), then o_grant = 4'b0100.
- All four masters hold CYC and each releases after one ACK -> grant order 0,1,2,3,0 with no repeats.
- TIMEOUT = 5, slave never acks:
  - o_merr[g] is high exactly in the 6th STB cycle, with o_sstb = 0 in that cycle.
  - Counter restarts from 0 if the master keeps STB asserted.
- i_sack asserted in the same cycle the counter hits TIMEOUT -> o_mack[g] = 1, o_merr = 0.
- Pull i_reset low mid-transfer with master 3 granted:
  - o_grant = 0 and o_scyc = 0 the next cycle; a late i_sack is not forwarded.
  - After release, master 0 wins a 4'b1001 request.
